// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit 7-segment scan controller.
// Segment patterns are active low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [3:0] ALL_OFF_AN  = 4'b1111;
  localparam logic [6:0] ALL_OFF_SEG = 7'b1111111;

  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of a four-digit 7-segment display with a blanking gap
// before every digit and a double-buffered value swapped only at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int BLANK_CYCLES = 1000,
  parameter int SHOW_CYCLES  = 99000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int MAX_CYCLES = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_valid_q, pend_valid_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_start_q, frame_start_d;

  logic          last_show;
  logic [3:0]    show_nib;
  logic [6:0]    dec_seg;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    last_show = (state_q == SHOW) && (cnt_q == SHOW_LAST) && (idx_q == 2'd3);
    if (state_q == BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == SHOW_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the pending buffer.
  always_comb begin
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    if (load) begin
      pending_d    = digits_in;
      pend_valid_d = 1'b1;
    end
    if (last_show) begin
      if (load) begin
        active_d = digits_in;
      end else if (pend_valid_q) begin
        active_d = pending_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  assign show_nib = active_d[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble_i (show_nib),
    .seg_o    (dec_seg)
  );

  // Outputs are derived from next-state so they switch on the same edge as the FSM.
  always_comb begin
    an_d          = ALL_OFF_AN;
    seg_d         = ALL_OFF_SEG;
    dp_d          = 1'b1;
    frame_start_d = (state_d == SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
    if (state_d == SHOW) begin
      if (!blank_mask[idx_d]) begin
        an_d[idx_d] = 1'b0;
      end
      seg_d = dec_seg;
      dp_d  = ~dp_in[idx_d];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= BLANK;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      active_q      <= 16'h0000;
      pending_q     <= 16'h0000;
      pend_valid_q  <= 1'b0;
      seg_q         <= ALL_OFF_SEG;
      dp_q          <= 1'b1;
      an_q          <= ALL_OFF_AN;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pend_valid_q  <= pend_valid_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with BLANK_CYCLES=2, SHOW_CYCLES=5.
// t counts clock edges since the most recent reset release.
module tb_seg7_scan_ctrl;

  localparam int BC    = 2;
  localparam int SC    = 5;
  localparam int SLOT  = BC + SC;
  localparam int FRAME = 4 * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digitsIn = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dpIn = 4'b0000;
  logic [3:0]  blankMask = 4'b0000;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frameStart;

  int t = 0;
  int checkCount = 0;
  int passCount = 0;

  seg7_scan_ctrl #(
    .BLANK_CYCLES (BC),
    .SHOW_CYCLES  (SC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .digits_in   (digitsIn),
    .load        (load),
    .dp_in       (dpIn),
    .blank_mask  (blankMask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frameStart)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic isShow(input int tt);
    return (tt % SLOT) >= BC;
  endfunction

  function automatic int slotIdx(input int tt);
    return (tt / SLOT) % 4;
  endfunction

  function automatic logic [3:0] expAn(input int tt, input logic [3:0] mask);
    logic [3:0] a;
    a = 4'b1111;
    if (isShow(tt) && !mask[slotIdx(tt)]) a[slotIdx(tt)] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] expSeg(input int tt, input logic [15:0] val);
    logic [15:0] sh;
    sh = val >> (4 * slotIdx(tt));
    return isShow(tt) ? segOf(sh[3:0]) : 7'b1111111;
  endfunction

  function automatic logic expDp(input int tt, input logic [3:0] dpv);
    return isShow(tt) ? ~dpv[slotIdx(tt)] : 1'b1;
  endfunction

  function automatic logic expFs(input int tt);
    return (tt % FRAME) == (FRAME - 1);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checkCount++; if (an !== 4'b1111) $display("[TB] FAIL reset_an got %b exp 1111", an); else passCount++;
    checkCount++; if (seg !== 7'b1111111) $display("[TB] FAIL reset_seg got %b exp 1111111", seg); else passCount++;
    checkCount++; if (dp !== 1'b1) $display("[TB] FAIL reset_dp got %b exp 1", dp); else passCount++;
    checkCount++; if (frameStart !== 1'b0) $display("[TB] FAIL reset_fs got %b exp 0", frameStart); else passCount++;
    reset = 1'b0;
    t = 0;
  endtask

  task automatic test_scan();
    while (t < 2 * FRAME) begin
      checkCount++; if (an !== expAn(t, 4'b0)) $display("[TB] FAIL scan_an t=%0d got %b exp %b", t, an, expAn(t, 4'b0)); else passCount++;
      checkCount++; if (seg !== expSeg(t, 16'h0)) $display("[TB] FAIL scan_seg t=%0d got %b exp %b", t, seg, expSeg(t, 16'h0)); else passCount++;
      checkCount++; if (dp !== expDp(t, 4'b0)) $display("[TB] FAIL scan_dp t=%0d got %b exp %b", t, dp, expDp(t, 4'b0)); else passCount++;
      checkCount++; if (frameStart !== expFs(t)) $display("[TB] FAIL scan_fs t=%0d got %b exp %b", t, frameStart, expFs(t)); else passCount++;
      step();
    end
  endtask

  task automatic test_load();
    logic [15:0] v;
    while (t < 4 * FRAME) begin
      v = (t < 3 * FRAME) ? 16'h0000 : 16'h1234;
      checkCount++; if (an !== expAn(t, 4'b0)) $display("[TB] FAIL load_an t=%0d got %b exp %b", t, an, expAn(t, 4'b0)); else passCount++;
      checkCount++; if (seg !== expSeg(t, v)) $display("[TB] FAIL load_seg t=%0d got %b exp %b", t, seg, expSeg(t, v)); else passCount++;
      checkCount++; if (frameStart !== expFs(t)) $display("[TB] FAIL load_fs t=%0d got %b exp %b", t, frameStart, expFs(t)); else passCount++;
      digitsIn = 16'h1234;
      load = (t == 2 * FRAME + SLOT + BC);
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_last_write();
    logic [15:0] v;
    while (t < 6 * FRAME - 1) begin
      v = (t < 5 * FRAME) ? 16'h1234 : 16'h5555;
      checkCount++; if (an !== expAn(t, 4'b0)) $display("[TB] FAIL lw_an t=%0d got %b exp %b", t, an, expAn(t, 4'b0)); else passCount++;
      checkCount++; if (seg !== expSeg(t, v)) $display("[TB] FAIL lw_seg t=%0d got %b exp %b", t, seg, expSeg(t, v)); else passCount++;
      digitsIn = (t < 4 * FRAME + 10) ? 16'hAAAA : 16'h5555;
      load = (t == 4 * FRAME + 3) || (t == 4 * FRAME + 18);
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_boundary_load();
    checkCount++; if (frameStart !== 1'b1) $display("[TB] FAIL bnd_fs t=%0d got %b exp 1", t, frameStart); else passCount++;
    checkCount++; if (seg !== segOf(4'h5)) $display("[TB] FAIL bnd_seg t=%0d got %b exp %b", t, seg, segOf(4'h5)); else passCount++;
    digitsIn = 16'hF00F;
    load = 1'b1;
    step();
    load = 1'b0;
    checkCount++; if (dut.pend_valid_q !== 1'b0) $display("[TB] FAIL bnd_pend_valid got %b exp 0", dut.pend_valid_q); else passCount++;
    while (t < 7 * FRAME) begin
      checkCount++; if (an !== expAn(t, 4'b0)) $display("[TB] FAIL bnd_an t=%0d got %b exp %b", t, an, expAn(t, 4'b0)); else passCount++;
      checkCount++; if (seg !== expSeg(t, 16'hF00F)) $display("[TB] FAIL bnd_seg t=%0d got %b exp %b", t, seg, expSeg(t, 16'hF00F)); else passCount++;
      step();
    end
  endtask

  task automatic test_mask_dp();
    blankMask = 4'b0100;
    dpIn = 4'b0001;
    while (t < 8 * FRAME) begin
      checkCount++; if (an !== expAn(t, 4'b0100)) $display("[TB] FAIL mask_an t=%0d got %b exp %b", t, an, expAn(t, 4'b0100)); else passCount++;
      checkCount++; if (seg !== expSeg(t, 16'hF00F)) $display("[TB] FAIL mask_seg t=%0d got %b exp %b", t, seg, expSeg(t, 16'hF00F)); else passCount++;
      checkCount++; if (dp !== expDp(t, 4'b0001)) $display("[TB] FAIL mask_dp t=%0d got %b exp %b", t, dp, expDp(t, 4'b0001)); else passCount++;
      checkCount++; if (frameStart !== expFs(t)) $display("[TB] FAIL mask_fs t=%0d got %b exp %b", t, frameStart, expFs(t)); else passCount++;
      step();
    end
    blankMask = 4'b0000;
    dpIn = 4'b0000;
  endtask

  task automatic test_reset_mid();
    while (t < 8 * FRAME + 2 * SLOT + BC + 2) begin
      checkCount++; if (seg !== expSeg(t, 16'hF00F)) $display("[TB] FAIL rm_seg t=%0d got %b exp %b", t, seg, expSeg(t, 16'hF00F)); else passCount++;
      digitsIn = 16'h9876;
      load = (t == 8 * FRAME + 6);
      step();
    end
    load = 1'b0;
    checkCount++; if (an !== 4'b1011) $display("[TB] FAIL rm_pre_an got %b exp 1011", an); else passCount++;
    reset = 1'b1;
    #1;
    checkCount++; if (an !== 4'b1111) $display("[TB] FAIL rm_async_an got %b exp 1111", an); else passCount++;
    checkCount++; if (seg !== 7'b1111111) $display("[TB] FAIL rm_async_seg got %b exp 1111111", seg); else passCount++;
    checkCount++; if (dp !== 1'b1) $display("[TB] FAIL rm_async_dp got %b exp 1", dp); else passCount++;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    t = 0;
    while (t < 2 * FRAME) begin
      checkCount++; if (an !== expAn(t, 4'b0)) $display("[TB] FAIL rm_an t=%0d got %b exp %b", t, an, expAn(t, 4'b0)); else passCount++;
      checkCount++; if (seg !== expSeg(t, 16'h0)) $display("[TB] FAIL rm_seg2 t=%0d got %b exp %b", t, seg, expSeg(t, 16'h0)); else passCount++;
      checkCount++; if (frameStart !== expFs(t)) $display("[TB] FAIL rm_fs t=%0d got %b exp %b", t, frameStart, expFs(t)); else passCount++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_last_write();
    test_boundary_load();
    test_mask_dp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
